dmem_req_ctrl: RTL and testbench

//  MEM-stage initiator for the data-side SRAM-like bus (req/addr_ok/data_ok). Takes one load/store per
//  MEM-stage instruction, runs the bus handshake, returns aligned, extended load data as mem_rdata to
//  the MEM/WB segment. Raises stall_req until the access completes; drains in-flight accesses on refresh.

---
 rtl/dmem_pkg.sv | 43 ++++
 rtl/dmem_load_align.sv | 23 ++
 rtl/dmem_req_ctrl.sv | 116 +++++++++++
 tb/tb_dmem_req_ctrl.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-side memory request controller.
// Store byte-enable and lane-replication helpers live here so the top stays readable.
package dmem_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StReq,
        StWait,
        StDone,
        StDrain
    } state_e;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;

    function automatic logic [3:0] calc_wstrb(input logic       wr,
                                              input logic [1:0] size,
                                              input logic [1:0] addr_lo);
        logic [3:0] strb;
        strb = 4'b0000;
        if (wr) begin
            unique case (size)
                SIZE_B:  strb = 4'b0001 << addr_lo;
                SIZE_H:  strb = addr_lo[1] ? 4'b1100 : 4'b0011;
                default: strb = 4'b1111;
            endcase
        end
        return strb;
    endfunction

    function automatic logic [31:0] replicate(input logic [1:0]  size,
                                              input logic [31:0] wdata);
        logic [31:0] rep;
        unique case (size)
            SIZE_B:  rep = {4{wdata[7:0]}};
            SIZE_H:  rep = {2{wdata[15:0]}};
            default: rep = wdata;
        endcase
        return rep;
    endfunction

endpackage

// File: rtl/dmem_load_align.sv
// Load data aligner: picks the addressed byte/half out of the raw bus word and extends it.
module dmem_load_align
    import dmem_pkg::*;
(
    input  logic [31:0] raw,
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic        lsext,
    output logic [31:0] result
);

    logic [31:0] shifted;

    always_comb begin
        shifted = raw >> {addr_lo, 3'b000};
        unique case (size)
            SIZE_B:  result = {{24{lsext & shifted[7]}}, shifted[7:0]};
            SIZE_H:  result = {{16{lsext & shifted[15]}}, shifted[15:0]};
            default: result = raw;
        endcase
    end

endmodule

// File: rtl/dmem_req_ctrl.sv
// MEM-stage initiator for the SRAM-like data bus: one outstanding access, stall until done,
// and drain of an accepted request when the pipeline is flushed.
module dmem_req_ctrl
    import dmem_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              refresh,
    input  logic              stall,
    input  logic              mem_ren,
    input  logic              mem_wen,
    input  logic [1:0]        mem_size,
    input  logic              mem_lsext,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic              data_req,
    output logic              data_wr,
    output logic [1:0]        data_size,
    output logic [ADDR_W-1:0] data_addr,
    output logic [3:0]        data_wstrb,
    output logic [DATA_W-1:0] data_wdata,
    input  logic              data_addr_ok,
    input  logic              data_data_ok,
    input  logic [DATA_W-1:0] data_rdata,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              stall_req
);

    state_e            state_q, state_d;
    logic              acc;
    logic              cap;
    logic              lsext_q;
    logic [DATA_W-1:0] aligned;
    logic [DATA_W-1:0] rdata_q;

    assign acc = (mem_ren | mem_wen) & ~refresh;
    // Response belongs to the live request (not a drained one).
    assign cap = data_data_ok & ((state_q == StWait) | ((state_q == StReq) & data_addr_ok));

    dmem_load_align u_align (
        .raw     (data_rdata),
        .addr_lo (data_addr[1:0]),
        .size    (data_size),
        .lsext   (lsext_q),
        .result  (aligned)
    );

    always_comb begin
        state_d   = state_q;
        stall_req = 1'b0;
        unique case (state_q)
            StIdle: begin
                stall_req = acc;
                if (acc) state_d = StReq;
            end
            StReq: begin
                stall_req = ~(data_addr_ok & data_data_ok);
                if (data_addr_ok) begin
                    if (refresh)           state_d = data_data_ok ? StIdle : StDrain;
                    else if (data_data_ok) state_d = stall ? StDone : StIdle;
                    else                   state_d = StWait;
                end else if (refresh) begin
                    state_d = StIdle;
                end
            end
            StWait: begin
                stall_req = ~data_data_ok;
                if (data_data_ok)  state_d = (stall & ~refresh) ? StDone : StIdle;
                else if (refresh)  state_d = StDrain;
            end
            StDone: begin
                if (refresh | ~stall) state_d = StIdle;
            end
            StDrain: begin
                stall_req = 1'b1;
                if (data_data_ok) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= StIdle;
            data_wr    <= 1'b0;
            data_size  <= 2'd0;
            data_addr  <= '0;
            data_wstrb <= 4'b0000;
            data_wdata <= '0;
            lsext_q    <= 1'b0;
            rdata_q    <= '0;
        end else begin
            state_q <= state_d;
            if ((state_q == StIdle) && acc) begin
                data_wr    <= mem_wen;
                data_size  <= mem_size;
                data_addr  <= mem_addr;
                data_wstrb <= calc_wstrb(mem_wen, mem_size, mem_addr[1:0]);
                data_wdata <= replicate(mem_size, mem_wdata);
                lsext_q    <= mem_lsext;
            end
            if (cap) rdata_q <= aligned;
        end
    end

    assign data_req  = (state_q == StReq);
    assign mem_rdata = cap ? aligned : rdata_q;

    // A response with nothing outstanding is a bus protocol violation.
    assert property (@(posedge clk) disable iff (!resetn)
        data_data_ok |-> (state_q inside {StReq, StWait, StDrain}));

endmodule

// File: tb/tb_dmem_req_ctrl.sv
// Self-checking bench for dmem_req_ctrl: vector table plus multi-cycle corner sequences.
module tb_dmem_req_ctrl;

    logic        clk = 1'b0;
    logic        resetn;
    logic        refresh, stall, mem_ren, mem_wen, mem_lsext;
    logic [1:0]  mem_size;
    logic [31:0] mem_addr, mem_wdata;
    logic        data_req, data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr, data_wdata;
    logic [3:0]  data_wstrb;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata, mem_rdata;
    logic        stall_req;

    always #5 clk = ~clk;

    dmem_req_ctrl dut (
        .clk          (clk),
        .resetn       (resetn),
        .refresh      (refresh),
        .stall        (stall),
        .mem_ren      (mem_ren),
        .mem_wen      (mem_wen),
        .mem_size     (mem_size),
        .mem_lsext    (mem_lsext),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_size    (data_size),
        .data_addr    (data_addr),
        .data_wstrb   (data_wstrb),
        .data_wdata   (data_wdata),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .data_rdata   (data_rdata),
        .mem_rdata    (mem_rdata),
        .stall_req    (stall_req)
    );

    typedef struct {
        logic        wr;
        logic [1:0]  size;
        logic        lsext;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic [3:0]  wstrb;
        logic [31:0] bus_wdata;
        logic [31:0] exp_rdata;
    } vec_t;

    typedef struct {
        logic        load;
        logic [31:0] rdata;
    } exp_t;

    localparam int NV = 11;
    vec_t v [NV];
    exp_t sb_q [$];
    exp_t e;
    int   checks = 0;
    int   failures = 0;

    function automatic void chk(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endfunction

    // MEM/WB captures whenever the stage has an instruction and nothing holds it.
    always @(negedge clk) begin
        if (resetn && (mem_ren || mem_wen) && !stall_req && !stall && !refresh) begin
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_completion actual=1 expected=0");
            end else begin
                e = sb_q.pop_front();
                if (e.load) chk("mem_rdata", mem_rdata, e.rdata);
                else        chk("store_done_wr", {31'b0, data_wr}, 32'd1);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        mem_ren = 1'b0; mem_wen = 1'b0; mem_size = 2'd0; mem_lsext = 1'b0;
        mem_addr = 32'h0; mem_wdata = 32'h0;
    endtask

    task automatic issue(input logic wr, input logic [1:0] size, input logic lsext,
                         input logic [31:0] addr, input logic [31:0] wdata);
        mem_ren = ~wr; mem_wen = wr; mem_size = size; mem_lsext = lsext;
        mem_addr = addr; mem_wdata = wdata;
    endtask

    initial begin
        v[0]  = '{1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 4'b0000, 32'h0, 32'hDEADBEEF};
        v[1]  = '{1'b0, 2'd0, 1'b1, 32'h103, 32'h0, 32'h80112233, 4'b0000, 32'h0, 32'hFFFFFF80};
        v[2]  = '{1'b0, 2'd1, 1'b0, 32'h102, 32'h0, 32'h80112233, 4'b0000, 32'h0, 32'h00008011};
        v[3]  = '{1'b0, 2'd0, 1'b0, 32'h101, 32'h0, 32'h80112233, 4'b0000, 32'h0, 32'h00000022};
        v[4]  = '{1'b0, 2'd1, 1'b1, 32'h100, 32'h0, 32'h8011F233, 4'b0000, 32'h0, 32'hFFFFF233};
        v[5]  = '{1'b0, 2'd0, 1'b1, 32'h100, 32'h0, 32'h0000007F, 4'b0000, 32'h0, 32'h0000007F};
        v[6]  = '{1'b1, 2'd0, 1'b0, 32'h101, 32'h123456AB, 32'h0, 4'b0010, 32'hABABABAB, 32'h0};
        v[7]  = '{1'b1, 2'd1, 1'b0, 32'h102, 32'hFFFF1234, 32'h0, 4'b1100, 32'h12341234, 32'h0};
        v[8]  = '{1'b1, 2'd2, 1'b0, 32'h200, 32'hCAFEF00D, 32'h0, 4'b1111, 32'hCAFEF00D, 32'h0};
        v[9]  = '{1'b1, 2'd0, 1'b0, 32'h103, 32'h00000055, 32'h0, 4'b1000, 32'h55555555, 32'h0};
        v[10] = '{1'b1, 2'd1, 1'b0, 32'h100, 32'hABCD5678, 32'h0, 4'b0011, 32'h56785678, 32'h0};

        resetn = 1'b0; refresh = 1'b0; stall = 1'b0;
        data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = 32'h0;
        idle_inputs();
        #3;
        chk("rst_req", {31'b0, data_req}, 32'd0);
        chk("rst_stall_req", {31'b0, stall_req}, 32'd0);
        chk("rst_addr", data_addr, 32'd0);
        chk("rst_mem_rdata", mem_rdata, 32'd0);
        tick(); tick();
        resetn = 1'b1;

        // Table: minimum-latency accesses (addr_ok at t+1, data_ok at t+2).
        for (int i = 0; i < NV; i++) begin
            tick();
            issue(v[i].wr, v[i].size, v[i].lsext, v[i].addr, v[i].wdata);
            sb_q.push_back('{~v[i].wr, v[i].exp_rdata});
            #3;
            chk("t_issue_stall", {31'b0, stall_req}, 32'd1);
            chk("t_issue_req", {31'b0, data_req}, 32'd0);
            tick();
            data_addr_ok = 1'b1;
            #3;
            chk("t_req", {31'b0, data_req}, 32'd1);
            chk("t_wr", {31'b0, data_wr}, {31'b0, v[i].wr});
            chk("t_addr", data_addr, v[i].addr);
            chk("t_size", {30'b0, data_size}, {30'b0, v[i].size});
            chk("t_wstrb", {28'b0, data_wstrb}, {28'b0, v[i].wstrb});
            if (v[i].wr) chk("t_wdata", data_wdata, v[i].bus_wdata);
            tick();
            data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = v[i].rdata;
            #3;
            chk("t_dok_req", {31'b0, data_req}, 32'd0);
            chk("t_dok_stall", {31'b0, stall_req}, 32'd0);
            tick();
            data_data_ok = 1'b0; data_rdata = 32'h0;
            idle_inputs();
        end

        // addr_ok withheld for 3 cycles: request and fields must hold.
        tick();
        issue(1'b0, 2'd2, 1'b0, 32'h300, 32'h0);
        sb_q.push_back('{1'b1, 32'h11223344});
        for (int c = 0; c < 3; c++) begin
            tick();
            mem_addr = 32'hFFFF_FFF0 + c;  // upstream changes must not leak onto the bus
            #3;
            chk("hold_req", {31'b0, data_req}, 32'd1);
            chk("hold_addr", data_addr, 32'h300);
            chk("hold_stall", {31'b0, stall_req}, 32'd1);
        end
        data_addr_ok = 1'b1;
        tick();
        data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'h11223344;
        #3;
        chk("hold_dok_stall", {31'b0, stall_req}, 32'd0);
        tick();
        data_data_ok = 1'b0;
        idle_inputs();

        // Refresh while waiting: drain the stale response, ignore the next access until idle.
        tick();
        issue(1'b0, 2'd2, 1'b0, 32'h400, 32'h0);
        tick();
        data_addr_ok = 1'b1;
        tick();
        data_addr_ok = 1'b0; refresh = 1'b1;
        tick();
        refresh = 1'b0;
        issue(1'b0, 2'd2, 1'b0, 32'h500, 32'h0);
        sb_q.push_back('{1'b1, 32'h0BADCAFE});
        #3;
        chk("drain_req", {31'b0, data_req}, 32'd0);
        chk("drain_stall", {31'b0, stall_req}, 32'd1);
        tick();
        data_data_ok = 1'b1; data_rdata = 32'h99999999;
        #3;
        chk("drain_dok_req", {31'b0, data_req}, 32'd0);
        chk("drain_dok_stall", {31'b0, stall_req}, 32'd1);
        tick();
        data_data_ok = 1'b0;
        #3;
        chk("post_drain_req", {31'b0, data_req}, 32'd0);
        chk("post_drain_stall", {31'b0, stall_req}, 32'd1);
        tick();
        data_addr_ok = 1'b1;
        #3;
        chk("new_req", {31'b0, data_req}, 32'd1);
        chk("new_addr", data_addr, 32'h500);
        tick();
        data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'h0BADCAFE;
        tick();
        data_data_ok = 1'b0;
        idle_inputs();

        // Response under downstream stall: result held in DONE until released.
        tick();
        issue(1'b0, 2'd2, 1'b0, 32'h600, 32'h0);
        sb_q.push_back('{1'b1, 32'h13579BDF});
        tick();
        data_addr_ok = 1'b1;
        tick();
        data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'h13579BDF; stall = 1'b1;
        #3;
        chk("stl_dok_stall_req", {31'b0, stall_req}, 32'd0);
        for (int c = 0; c < 2; c++) begin
            tick();
            data_data_ok = 1'b0; data_rdata = 32'h2468ACE0 + c;
            #3;
            chk("done_rdata", mem_rdata, 32'h13579BDF);
            chk("done_req", {31'b0, data_req}, 32'd0);
            chk("done_stall_req", {31'b0, stall_req}, 32'd0);
        end
        tick();
        stall = 1'b0;
        tick();
        idle_inputs();
        #3;
        chk("after_done_req", {31'b0, data_req}, 32'd0);

        // Asynchronous reset while a store is waiting for its response.
        tick();
        issue(1'b1, 2'd2, 1'b0, 32'h700, 32'hFFFFFFFF);
        tick();
        data_addr_ok = 1'b1;
        tick();
        data_addr_ok = 1'b0;
        idle_inputs();
        resetn = 1'b0;
        #2;
        chk("arst_req", {31'b0, data_req}, 32'd0);
        chk("arst_wr", {31'b0, data_wr}, 32'd0);
        chk("arst_size", {30'b0, data_size}, 32'd0);
        chk("arst_addr", data_addr, 32'd0);
        chk("arst_wstrb", {28'b0, data_wstrb}, 32'd0);
        chk("arst_wdata", data_wdata, 32'd0);
        chk("arst_mem_rdata", mem_rdata, 32'd0);
        chk("arst_stall_req", {31'b0, stall_req}, 32'd0);
        tick();
        resetn = 1'b1;
        tick();
        tick();

        chk("scoreboard_empty", sb_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
